wb_cpu_master: RTL and testbench

- Single-master front end sitting directly upstream of the shared-bus Wishbone interconnect. It converts the CPU memory port's request/done handshake into one classic Wishbone cycle at a time.
- Its wbm_* outputs drive the interconnect's master inputs.
- The interconnect raises no error for unmapped addresses, so this block supplies a bus-timeout error.

---
 rtl/wb_cpu_master.sv | 168 ++++++++++++++++
 tb/tb_wb_cpu_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_master.sv
// -----------------------------------------------------------------------------
// wb_cpu_master
//
// Purpose:
//   Front end between a CPU memory port (request/done handshake) and a
//   shared-bus Wishbone interconnect. It runs one classic Wishbone cycle per
//   CPU request. The interconnect never errors on unmapped addresses, so this
//   block aborts a cycle that goes unacknowledged for too long and reports it
//   as an error.
//
// Parameters:
//   TIMEOUT   - wait cycles (stb high, no ack) before the cycle is aborted.
//               0 disables the timeout.
//   TIMEOUT_W - width of the wait counter; TIMEOUT <= 2**TIMEOUT_W - 1.
//
// Ports:
//   clk_i, rst_i     - clock and synchronous active-high reset
//   req_i            - CPU request, sampled only while idle
//   adr_i/dat_i      - CPU byte address / write data
//   sel_i, we_i      - CPU byte/half select, write enable
//   busy_o           - request in flight
//   done_o, err_o    - one-cycle completion pulse, error qualifier (timeout)
//   rdata_o          - read data, valid with done_o on reads
//   wbm_*_o          - Wishbone master outputs toward the interconnect
//   wbm_dat_i        - Wishbone read data
//   wbm_ack_i        - Wishbone acknowledge
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module wb_cpu_master #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [1:0]  sel_i,
    input  logic        we_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [1:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    // Counter value seen on the last permitted wait edge. The counter is
    // cleared when stb rises, so matching TIMEOUT-1 at an edge means stb has
    // been high for exactly TIMEOUT cycles.
    localparam logic [TIMEOUT_W-1:0] LP_CNT_LAST =
        (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

    state_t                r_state;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic [31:0]           r_adr;
    logic [31:0]           r_dat;
    logic [1:0]            r_sel;
    logic                  r_we;
    logic                  r_cyc;
    logic                  r_stb;

    logic                  w_timeout;

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Stray acks are ignored here: nothing below looks at
                    // wbm_ack_i or wbm_dat_i while idle.
                    if (req_i) begin
                        r_adr   <= adr_i;
                        r_dat   <= dat_i;
                        r_sel   <= sel_i;
                        r_we    <= we_i;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    // req_i is deliberately not looked at: requests that
                    // arrive while busy are dropped, not queued.
                    if (wbm_ack_i) begin
                        // Ack has priority over a coincident timeout.
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= wbm_dat_i;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        // With TIMEOUT=0 the counter simply wraps; it is
                        // never compared in that case.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign rdata_o   = r_rdata;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;

endmodule

// File: tb/tb_wb_cpu_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cpu_master
//
// Self-checking bench for wb_cpu_master (TIMEOUT=4). A transaction-level
// reference predicts, from the request and the slave's ack delay, how many
// stb cycles the transfer lasts, whether it errors and what rdata_o shows.
// -----------------------------------------------------------------------------
module tb_wb_cpu_master;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [1:0]  sel;
    logic        we;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] w_adr;
    logic [31:0] w_dato;
    logic [1:0]  w_sel;
    logic        w_we;
    logic        cyc;
    logic        stb;
    logic [31:0] w_dati;
    logic        ack;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: last value rdata_o must show.
    logic [31:0] exp_rdata = '0;

    wb_cpu_master #(
        .TIMEOUT   (TMO),
        .TIMEOUT_W (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .adr_i     (adr),
        .dat_i     (dat),
        .sel_i     (sel),
        .we_i      (we),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .rdata_o   (rdata),
        .wbm_adr_o (w_adr),
        .wbm_dat_o (w_dato),
        .wbm_sel_o (w_sel),
        .wbm_we_o  (w_we),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_dat_i (w_dati),
        .wbm_ack_i (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_err"},   {31'd0, err},  32'd0);
        chk({tag, "_rdata"}, rdata,         32'd0);
        chk({tag, "_adr"},   w_adr,         32'd0);
        chk({tag, "_dat"},   w_dato,        32'd0);
        chk({tag, "_sel"},   {30'd0, w_sel}, 32'd0);
        chk({tag, "_we"},    {31'd0, w_we}, 32'd0);
        chk({tag, "_cyc"},   {31'd0, cyc},  32'd0);
        chk({tag, "_stb"},   {31'd0, stb},  32'd0);
    endtask

    // One CPU transfer. delay = stb cycle index (0-based) in which the slave
    // acks; delay >= TMO means the slave never acks. noisy toggles req_i and
    // the CPU-side inputs while the cycle is in flight.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic w, input int delay, input logic [31:0] ackdat,
                        input bit noisy);
        int  n;
        int  exp_cyc;
        bit  exp_err;
        bit  got;
        @(negedge clk);
        req = 1'b1; adr = a; dat = d; sel = s; we = w; ack = 1'b0;
        tick();
        chk("start_cyc",  {31'd0, cyc},  32'd1);
        chk("start_stb",  {31'd0, stb},  32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);

        exp_err = (delay >= TMO);
        exp_cyc = exp_err ? TMO : delay + 1;
        n   = 0;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            req = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                adr = $urandom; dat = $urandom; sel = 2'($urandom); we = 1'($urandom);
            end
            ack    = (n == delay);
            w_dati = (n == delay) ? ackdat : $urandom;
            tick();
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk("bus_stb", {31'd0, stb},  32'd1);
                chk("bus_cyc", {31'd0, cyc},  32'd1);
                chk("bus_adr", w_adr,          a);
                chk("bus_dat", w_dato,         d);
                chk("bus_sel", {30'd0, w_sel}, {30'd0, s});
                chk("bus_we",  {31'd0, w_we},  {31'd0, w});
                if (n > TMO + 4) begin
                    chk("done_wait_expired", 32'd0, 32'd1);
                    got = 1'b1;
                end
            end
        end

        if (exp_err)  exp_rdata = '0;
        else if (!w)  exp_rdata = ackdat;
        chk("stb_cycles", n,             exp_cyc);
        chk("done_err",   {31'd0, err},  {31'd0, exp_err});
        chk("done_rdata", rdata,         exp_rdata);
        chk("done_stb",   {31'd0, stb},  32'd0);
        chk("done_busy",  {31'd0, busy}, 32'd0);

        // Idle cycle with a possible stray ack: done must not repeat.
        @(negedge clk);
        req = 1'b0; ack = 1'($urandom_range(0, 1)); w_dati = $urandom;
        tick();
        chk("idle_done",  {31'd0, done}, 32'd0);
        chk("idle_err",   {31'd0, err},  32'd0);
        chk("idle_cyc",   {31'd0, cyc},  32'd0);
        chk("idle_rdata", rdata,         exp_rdata);
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int nstb;
        int ndone;
        logic [31:0] pend;
        rst = 1'b1; req = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0;
        ack = 1'b0; w_dati = '0;
        tick();
        tick();
        chk_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait read.
        xfer(32'h0000_0040, 32'h0, 2'b11, 1'b0, 0, 32'hCAFE_BABE, 1'b0);
        // Wait-state write, ack in third stb cycle; rdata must hold.
        xfer(32'h0000_1000, 32'h1234_5678, 2'b01, 1'b1, 2, 32'hDEAD_0000, 1'b0);
        // Timeout with no ack.
        xfer(32'h0000_2000, 32'h0, 2'b10, 1'b0, 99, 32'h0, 1'b0);
        // Ack in the last permitted cycle beats the timeout.
        xfer(32'h0000_2004, 32'h0, 2'b11, 1'b0, TMO - 1, 32'h5A5A_A5A5, 1'b0);

        // Stray acks in IDLE.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ack = 1'b1; w_dati = $urandom;
            tick();
            chk("stray_done",  {31'd0, done}, 32'd0);
            chk("stray_rdata", rdata,         exp_rdata);
        end
        @(negedge clk);
        ack = 1'b0;

        // Back-to-back: req held 10 cycles, slave acks whenever stb is up.
        nstb = 0; ndone = 0; pend = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            req = (i <= 10); we = 1'b0; adr = $urandom; sel = 2'b11;
            ack = stb; w_dati = $urandom;
            if (stb) pend = w_dati;
            tick();
            if (i <= 10) chk("b2b_stb", {31'd0, stb}, {31'd0, 1'(i % 2)});
            if (stb) nstb++;
            if (done) begin
                ndone++;
                exp_rdata = pend;
                chk("b2b_rdata", rdata, exp_rdata);
            end
        end
        chk("b2b_transfers", nstb,  32'd5);
        chk("b2b_dones",     ndone, 32'd5);
        @(negedge clk);
        req = 1'b0; ack = 1'b0;

        // Randomized transfers, with noise on req_i during BUS.
        for (int t = 0; t < 30; t++) begin
            xfer($urandom, $urandom, 2'($urandom), 1'($urandom),
                 int'($urandom_range(0, TMO + 2)), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        req = 1'b1; adr = 32'h0000_0100; dat = 32'hA5A5_0001; sel = 2'b11; we = 1'b0;
        tick();
        chk("mid_cyc", {31'd0, cyc}, 32'd1);
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_cyc",  {31'd0, cyc},  32'd0);
        chk("midrst_stb",  {31'd0, stb},  32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        tick();
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0; exp_rdata = '0;
        tick();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_cyc",  {31'd0, cyc},  32'd0);

        // A transfer still works after reset.
        xfer(32'h0000_0044, 32'h0, 2'b11, 1'b0, 1, 32'h0BAD_F00D, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
